// File: rtl/inst_mem_slave_pkg.sv
// Shared bus widths, FSM state encoding and address helpers for the
// instruction memory slave and its line RAM.
package inst_mem_slave_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BYTE_W = 16;
    localparam int unsigned DATA_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_BUSY = 2'd2
    } state_e;

    // Any set bit at or above idx_top lies outside the stored lines.
    function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr,
                                               input int unsigned      idx_top);
        return (addr >> idx_top) != '0;
    endfunction

endpackage

// File: rtl/inst_line_ram.sv
// Single-port line RAM: 2^DEPTH_LOG2 x 128-bit, byte-lane write enables,
// registered read that only updates when a read is issued.
module inst_line_ram
    import inst_mem_slave_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [BYTE_W-1:0]     be_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned b = 0; b < BYTE_W; b++) begin
                if (be_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
        if (re_i) rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_mem_slave.sv
// Single-outstanding Avalon-MM-style line memory slave for icache refill,
// with configurable accept hold-off and read latency.
module inst_mem_slave
    import inst_mem_slave_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2   = 10,
    parameter int unsigned LINE_SHIFT   = 4,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned ACCEPT_DELAY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [BYTE_W-1:0] i_byte_en,
    input  logic [DATA_W-1:0] i_writedata,
    input  logic              i_read,
    input  logic              i_write,
    output logic [DATA_W-1:0] o_readdata,
    output logic              o_readdata_valid,
    output logic              o_waitrequest,
    output logic              o_err
);

    localparam int unsigned IDX_TOP = LINE_SHIFT + DEPTH_LOG2;
    localparam logic [3:0]  AD_C    = 4'(ACCEPT_DELAY);
    localparam logic [3:0]  RL_LAST = 4'(READ_LATENCY - 1);

    state_e      state_q;
    logic [3:0]  hold_cnt_q;
    logic [3:0]  lat_cnt_q;
    logic        valid_q;
    logic        oor_rd_q;
    logic        err_q;

    logic              req;
    logic              accept;
    logic              oor;
    logic              rd_acc;
    logic              wr_en;
    logic [DATA_W-1:0] ram_rdata;
    logic              unused_low;

    assign req        = i_read | i_write;
    assign oor        = addr_out_of_range(i_addr, IDX_TOP);
    assign accept     = req & ~o_waitrequest;
    assign rd_acc     = accept & i_read & ~i_write;
    assign wr_en      = accept & i_write & ~oor;
    assign unused_low = ^i_addr[LINE_SHIFT-1:0];

    always_comb begin
        o_waitrequest = 1'b1;
        if (!rst) begin
            case (state_q)
                ST_BUSY: o_waitrequest = 1'b1;
                ST_HOLD: o_waitrequest = (hold_cnt_q != AD_C);
                default: o_waitrequest = req && (ACCEPT_DELAY != 0);
            endcase
        end
    end

    inst_line_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_en),
        .re_i    (rd_acc),
        .addr_i  (i_addr[IDX_TOP-1:LINE_SHIFT]),
        .be_i    (i_byte_en),
        .wdata_i (i_writedata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            lat_cnt_q  <= '0;
            valid_q    <= 1'b0;
            oor_rd_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (accept && (oor || (i_read && i_write))) err_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (req && !accept) begin
                        state_q    <= ST_HOLD;
                        hold_cnt_q <= 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (!req || accept) begin
                        state_q    <= ST_IDLE;
                        hold_cnt_q <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 4'd1;
                    end
                end
                ST_BUSY: begin
                    if (lat_cnt_q == RL_LAST) begin
                        state_q   <= ST_IDLE;
                        lat_cnt_q <= '0;
                        valid_q   <= 1'b1;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Read acceptance (IDLE or HOLD) overrides the state chosen above.
            if (rd_acc) begin
                oor_rd_q <= oor;
                if (READ_LATENCY == 1) begin
                    valid_q <= 1'b1;
                end else begin
                    state_q   <= ST_BUSY;
                    lat_cnt_q <= 4'd1;
                end
            end
        end
    end

    assign o_readdata_valid = valid_q;
    assign o_readdata       = (valid_q && !oor_rd_q) ? ram_rdata : '0;
    assign o_err            = err_q;

endmodule

// File: tb/tb_inst_mem_slave.sv
// Randomised scoreboard bench for inst_mem_slave: a cycle-level protocol
// model predicts accept/response timing, line contents and the error flag.
module tb_inst_mem_slave;
    import inst_mem_slave_pkg::*;

    localparam int unsigned DL     = 6;
    localparam int unsigned LS     = 4;
    localparam int unsigned RL     = 3;
    localparam int unsigned AD     = 2;
    localparam int unsigned NLINES = 1 << DL;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] i_addr;
    logic [BYTE_W-1:0] i_byte_en;
    logic [DATA_W-1:0] i_writedata;
    logic              i_read;
    logic              i_write;
    logic [DATA_W-1:0] o_readdata;
    logic              o_readdata_valid;
    logic              o_waitrequest;
    logic              o_err;

    inst_mem_slave #(
        .DEPTH_LOG2   (DL),
        .LINE_SHIFT   (LS),
        .READ_LATENCY (RL),
        .ACCEPT_DELAY (AD)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_addr           (i_addr),
        .i_byte_en        (i_byte_en),
        .i_writedata      (i_writedata),
        .i_read           (i_read),
        .i_write          (i_write),
        .o_readdata       (o_readdata),
        .o_readdata_valid (o_readdata_valid),
        .o_waitrequest    (o_waitrequest),
        .o_err            (o_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] data;
    } resp_t;

    resp_t             exp_q[$];
    resp_t             mon_r;
    logic [DATA_W-1:0] mem_m [NLINES];
    bit                err_m;
    int                free_at;
    int                checks = 0;
    int                errors = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Every response pulse must match the oldest predicted response.
    always @(negedge clk) begin
        if (o_readdata_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid cyc=%0d got=1 want=0", cyc);
            end else begin
                mon_r = exp_q.pop_front();
                check("rvalid_cycle", DATA_W'(cyc), DATA_W'(mon_r.cyc));
                check("rdata", o_readdata, mon_r.data);
            end
        end
    end

    // Model effect of a request accepted in cycle acc.
    task automatic model_accept(input bit rd, input bit wr, input logic [31:0] a,
                                input logic [15:0] be, input logic [DATA_W-1:0] d,
                                input int acc);
        bit oor;
        int line;
        oor  = (a >> (LS + DL)) != 0;
        line = int'(a[LS+DL-1:LS]);
        if (oor || (rd && wr)) err_m = 1'b1;
        if (rd && !wr) begin
            exp_q.push_back('{acc + RL, oor ? '0 : mem_m[line]});
            free_at = acc + RL;
        end else begin
            free_at = acc + 1;
        end
        if (wr && !oor)
            for (int b = 0; b < 16; b++)
                if (be[b]) mem_m[line][b*8 +: 8] = d[b*8 +: 8];
    endtask

    // Present a request at the current cycle; hold until the predicted accept,
    // or only for drop_after cycles when drop_after > 0.
    task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [15:0] be, input logic [DATA_W-1:0] d,
                         input int drop_after);
        int start;
        int acc;
        start = cyc;
        acc   = ((cyc > free_at) ? cyc : free_at) + AD;
        i_read = rd; i_write = wr; i_addr = a; i_byte_en = be; i_writedata = d;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            check("err_flag", DATA_W'(o_err), DATA_W'(err_m));
            check("waitreq", DATA_W'(o_waitrequest), DATA_W'(cyc != acc));
            if (drop_after > 0 && cyc - start == drop_after - 1) break;
            if (cyc == acc) begin
                model_accept(rd, wr, a, be, d, acc);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        i_read = 1'b0; i_write = 1'b0;
        i_addr = $urandom; i_byte_en = 16'($urandom); i_writedata = rnd128();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            check("err_flag", DATA_W'(o_err), DATA_W'(err_m));
            if (cyc < free_at) check("waitreq_busy", DATA_W'(o_waitrequest), 1);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            @(negedge clk);
            check("waitreq_rst", DATA_W'(o_waitrequest), 1);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        exp_q.delete();
        err_m   = 1'b0;
        free_at = cyc;
        @(negedge clk);
        check("valid_after_rst", DATA_W'(o_readdata_valid), 0);
        check("err_after_rst", DATA_W'(o_err), 0);
        check("rdata_after_rst", o_readdata, '0);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = {22'd0, 6'($urandom_range(0, NLINES - 1)), 4'($urandom)};
        if ($urandom_range(0, 9) == 0) a[$urandom_range(LS + DL, 31)] = 1'b1;
        return a;
    endfunction

    initial begin
        int kind;
        rst = 1'b1; i_read = 1'b0; i_write = 1'b0;
        i_addr = '0; i_byte_en = '0; i_writedata = '0;
        err_m = 1'b0; free_at = 0;
        for (int i = 0; i < int'(NLINES); i++) mem_m[i] = '0;
        @(posedge clk); #1;
        do_reset(3);

        for (int i = 0; i < int'(NLINES); i++) begin
            logic [DATA_W-1:0] d;
            d = (i == 3) ? {4{32'h0000_0013}} : (i == 4) ? '0 : rnd128();
            issue(1'b0, 1'b1, 32'(i << LS), 16'hFFFF, d, 0);
        end

        issue(1'b1, 1'b0, 32'h30, '0, '0, 0);                  // line 3 pattern
        issue(1'b0, 1'b1, 32'h40, 16'h000F, '1, 0);            // low 4 bytes only
        issue(1'b1, 1'b0, 32'h40, '0, '0, 0);
        issue(1'b0, 1'b1, 32'h34, 16'h0000, '1, 0);            // byte_en=0 no-op
        issue(1'b1, 1'b0, 32'h30, '0, '0, 0);
        idle(RL);
        issue(1'b1, 1'b0, 32'h10, '0, '0, 1);                  // dropped in hold
        idle(RL + AD + 2);
        issue(1'b1, 1'b0, 32'h10, '0, '0, 0);
        issue(1'b1, 1'b0, 32'h00, '0, '0, 0);                  // back-to-back
        issue(1'b1, 1'b0, 32'h10, '0, '0, 0);
        issue(1'b1, 1'b0, 32'h20, '0, '0, 0);
        issue(1'b1, 1'b0, 32'h0000_1000, '0, '0, 0);           // out of range
        idle(RL + 2);
        issue(1'b1, 1'b0, 32'h20, '0, '0, 0);
        do_reset(2);                                           // cancels read
        idle(RL + 2);
        issue(1'b1, 1'b0, 32'h40, '0, '0, 0);
        issue(1'b1, 1'b1, 32'h50, 16'hFFFF, rnd128(), 0);      // both high
        idle(5);
        issue(1'b1, 1'b0, 32'h50, '0, '0, 0);
        issue(1'b0, 1'b1, 32'h8000_0040, 16'hFFFF, '1, 0);     // dropped write
        issue(1'b1, 1'b0, 32'h40, '0, '0, 0);
        do_reset(1);

        for (int t = 0; t < 300; t++) begin
            kind = int'($urandom_range(0, 19));
            if (kind < 9)       issue(1'b1, 1'b0, rnd_addr(), '0, '0, 0);
            else if (kind < 17) issue(1'b0, 1'b1, rnd_addr(), 16'($urandom), rnd128(), 0);
            else if (kind < 18) issue(1'b1, 1'b1, rnd_addr(), 16'($urandom), rnd128(), 0);
            else begin
                issue(1'b1, 1'b0, rnd_addr(), '0, '0, int'($urandom_range(1, AD)));
                idle(1);
            end
            idle(int'($urandom_range(0, 3)));
        end

        idle(RL + 4);
        check("pending_resp", DATA_W'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
